// File: rtl/div_unit.sv
// div_unit: fixed-latency 32-cycle restoring divider (DIV/DIVU) with pipeline stall, annul and sign correction
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [31:0] rem, quo, dvs, rem_n, quo_n;
  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic [5:0]  cnt;
  logic        sgn, sa, sb, borrow, accept, last;
  always_comb begin
    rem_sh  = {rem, quo[31]};
    diff    = {1'b0, rem_sh} - {2'b0, dvs};
    borrow  = diff[33];
    rem_n   = borrow ? rem_sh[31:0] : diff[31:0];
    quo_n   = {quo[30:0], ~borrow};
    accept  = state == IDLE && start_i && !annul_i;
    last    = state == BUSY && cnt == 6'd31;
    state_n = annul_i ? IDLE :
              state == IDLE ? (start_i ? BUSY : IDLE) :
              state == BUSY ? (last ? DONE : BUSY) : IDLE;
    stall_o = !annul_i && ((start_i && state == IDLE) || state == BUSY);
    ready_o = !annul_i && state == DONE;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // operands are stored as magnitudes; signs are reapplied when the result is latched
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      sa  <= 1'b0;
      sb  <= 1'b0;
      hi_o <= '0;
      lo_o <= '0;
    end else if (accept) begin
      rem <= '0;
      quo <= (signed_i && a_i[31]) ? -a_i : a_i;
      dvs <= (signed_i && b_i[31]) ? -b_i : b_i;
      cnt <= '0;
      sgn <= signed_i;
      sa  <= signed_i && a_i[31];
      sb  <= signed_i && b_i[31];
    end else if (state == BUSY) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + 6'd1;
      if (last && !annul_i) begin
        lo_o <= (sgn && (sa ^ sb)) ? -quo_n : quo_n;
        hi_o <= (sgn && sa) ? -rem_n : rem_n;
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit
module tb_div_unit;
  logic        clk = 1'b0;
  logic        resetn, start_i, signed_i, annul_i;
  logic [31:0] a_i, b_i, hi_o, lo_o;
  logic        stall_o, ready_o;
  int          checks = 0, errors = 0, cyc = 0, t_ready = 0, t_first = 0;
  logic [31:0] prev_lo = '0, prev_hi = '0;

  div_unit dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .annul_i(annul_i), .stall_o(stall_o),
    .ready_o(ready_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one full divide; start is held through BUSY when hold=1, else pulsed for the accept cycle only
  task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic hold, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    for (int k = 0; k <= 33; k++) begin
      @(posedge clk); #1;
      start_i = (k == 0) || (hold && k < 33);
      signed_i = s;
      a_i = a;
      b_i = b;
      @(negedge clk);
      chk($sformatf("%s stall c%0d", name, k), {31'b0, stall_o}, {31'b0, k <= 32});
      chk($sformatf("%s ready c%0d", name, k), {31'b0, ready_o}, {31'b0, k == 33});
      if (k == 32) begin
        chk({name, " lo held"}, lo_o, prev_lo);
        chk({name, " hi held"}, hi_o, prev_hi);
      end
      if (k == 33) begin
        t_ready = cyc;
        chk({name, " lo"}, lo_o, exp_lo);
        chk({name, " hi"}, hi_o, exp_hi);
      end
    end
    prev_lo = exp_lo;
    prev_hi = exp_hi;
  endtask

  initial begin
    resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst stall", {31'b0, stall_o}, 32'd0);
    chk("rst ready", {31'b0, ready_o}, 32'd0);
    chk("rst lo", lo_o, 32'd0);
    chk("rst hi", hi_o, 32'd0);
    start_i = 1'b1;
    #1 chk("rst stall start", {31'b0, stall_o}, 32'd1);
    start_i = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;

    run_div("u7/2", 1'b0, 32'd7, 32'd2, 1'b1, 32'd3, 32'd1);
    t_first = t_ready;
    run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF);
    chk("b2b spacing", t_ready - t_first, 32'd34);
    run_div("s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1);
    run_div("s min/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0);
    run_div("u5/0", 1'b0, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd5);
    run_div("s-7/0", 1'b1, 32'hFFFFFFF9, 32'd0, 1'b0, 32'd1, 32'hFFFFFFF9);
    run_div("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0);
    run_div("u min/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000);

    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      start_i = k < 10;
      signed_i = 1'b0; a_i = 32'd7; b_i = 32'd2;
      annul_i = k == 10;
      @(negedge clk);
      chk($sformatf("annul stall c%0d", k), {31'b0, stall_o}, {31'b0, k < 10});
      chk($sformatf("annul ready c%0d", k), {31'b0, ready_o}, 32'd0);
    end
    annul_i = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("annul no ready", {31'b0, ready_o}, 32'd0);
    end
    chk("annul lo kept", lo_o, prev_lo);
    chk("annul hi kept", hi_o, prev_hi);

    @(posedge clk); #1;
    start_i = 1'b1; annul_i = 1'b1;
    @(negedge clk);
    chk("idle annul+start stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle annul not busy", {31'b0, stall_o}, 32'd0);
    end

    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      start_i = k == 0; signed_i = 1'b0; a_i = 32'd1000; b_i = 32'd3;
      resetn = k != 5;
      @(negedge clk);
    end
    chk("midrst lo", lo_o, 32'd0);
    chk("midrst hi", hi_o, 32'd0);
    chk("midrst ready", {31'b0, ready_o}, 32'd0);
    chk("midrst stall", {31'b0, stall_o}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    prev_lo = '0;
    prev_hi = '0;
    run_div("u100/7", 1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start_i, input, 1 bit: an E-stage divide is present; held high by the pipeline while stalled.
REQ-004 SHALL have port signed_i, input, 1 bit: 1 = DIV, 0 = DIVU; sampled with start.
REQ-005 SHALL have port a_i, input, 32 bits: dividend (rs value).
REQ-006 SHALL have port b_i, input, 32 bits: divisor (rt value).
REQ-007 SHALL have port annul_i, input, 1 bit: exception/flush kills the operation in flight.
REQ-008 SHALL have port stall_o, output, 1 bit: stall request to the hazard unit (freezes F/D/E).
REQ-009 SHALL have port ready_o, output, 1 bit: result valid this cycle.
REQ-010 SHALL have port hi_o, output, 32 bits: remainder.
REQ-011 SHALL have port lo_o, output, 32 bits: quotient.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: when start_i=1 and annul_i=0, SHALL capture |a|, |b|, signed_i, sign(a), sign(b), clear the 6-bit counter, and go to BUSY.
REQ-014 BUSY: SHALL perform one restoring-division step per cycle (shift partial remainder left 1, trial-subtract divisor, set quotient bit on no borrow); after step 32 (counter=31) SHALL go to DONE.
REQ-015 DONE: SHALL assert ready_o and return to IDLE next cycle, regardless of start_i.
REQ-016 stall_o SHALL be combinational: (start_i=1 and state=IDLE) or state=BUSY; 0 in DONE so the divide instruction advances.
REQ-017 Latency SHALL be fixed: accept cycle N, BUSY N+1..N+32, DONE N+33; stall_o high for exactly 33 cycles (N..N+32).
REQ-018 Signed mode: quotient SHALL be negated when sign(a)≠sign(b); remainder SHALL take sign(a); unsigned mode SHALL apply no correction.
REQ-019 Signed 0x80000000/0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (two's-complement wrap, no trap).
REQ-020 Divide by zero SHALL complete with normal latency, giving unsigned result lo=0xFFFFFFFF, hi=dividend, with REQ-018 sign correction applied in signed mode.
REQ-021 hi_o/lo_o SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE.
REQ-022 annul_i=1 in any state SHALL force IDLE on the next edge and suppress ready_o and hi/lo update; stall_o SHALL drop in that same cycle.
REQ-023 annul_i and start_i both high in IDLE: annul SHALL win; no operation is accepted.
REQ-024 start_i falling during BUSY without annul SHALL NOT abort; the operation finishes and produces DONE.

Reset
REQ-025 While resetn=0: state=IDLE, counter=0, hi_o=0, lo_o=0, ready_o=0; stall_o=0 unless start_i=1.
REQ-026 Reset asserted mid-BUSY SHALL discard the operation; after release, the unit SHALL behave as idle and accept a new start.

Verification
REQ-027 Unsigned 7/2, start at cycle 0 -> stall_o=1 in cycles 0..32, ready_o=1 in cycle 33, lo=3, hi=1.
REQ-028 Signed -7 (0xFFFFFFF9)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; signed 7/-2 -> lo=0xFFFFFFFD, hi=1.
REQ-029 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-030 annul_i pulsed in BUSY cycle 10 -> IDLE next cycle, stall_o=0, no ready_o, hi/lo keep prior values.
REQ-031 Back-to-back divides (start_i high again in cycle after DONE) -> second result ready exactly 34 cycles after the first.
REQ-032 resetn low for 1 cycle mid-BUSY -> outputs zero, no ready_o; a following 100/7 unsigned divide gives lo=14, hi=2.
